// File: rtl/uart_tx_ws.sv
// uart_tx_ws: buffered UART transmitter, 8N1 framing (8E1 when PARITY_EN=1).
// Latency: a byte pushed into an empty FIFO while idle with ena=1 starts its start bit one cycle later.
// Backpressure: tx_ready falls while the FIFO holds 4 bytes; bytes offered then are dropped.
//
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   ena                 transmit enable; gates the start of new frames only
//   tx_data, tx_valid   byte input, accepted when tx_valid && tx_ready
//   tx_ready            FIFO not full
//   tx                  registered serial line, idle high
//   busy                frame in progress (FSM not IDLE)
//   fifo_count          FIFO occupancy, 0..4

// uart_tx_ws_fifo: 4-entry first-in first-out byte store with 2-bit wrapping pointers.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: a push while full is ignored; callers never pop while empty.
module uart_tx_ws_fifo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] push_dat_i,
  input  logic       pop_i,
  output logic [7:0] pop_dat_o,
  output logic [2:0] count_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [2:0] count_q;
  logic       push_ok;
  logic       pop_ok;

  assign full_o    = (count_q == 3'd4);
  assign empty_o   = (count_q == 3'd0);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // A pop on a full cycle does not open a slot until the next cycle, so
  // the full check here uses the registered count only.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

module uart_tx_ws #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic [2:0] fifo_count
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic             tx_q;
  logic             busy_q;

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic [2:0] fifo_cnt;
  logic       push_d;
  logic       pop_d;
  logic       baud_done;

  assign tx_ready   = !fifo_full;
  assign fifo_count = fifo_cnt;
  assign tx         = tx_q;
  assign busy       = busy_q;

  assign push_d    = tx_valid && tx_ready;
  assign baud_done = (baud_q == BAUD_LAST);

  // A new frame is taken either from idle or on the final stop cycle, the
  // latter giving back-to-back frames with no idle gap.
  assign pop_d = ena && !fifo_empty &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_done));

  uart_tx_ws_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_d),
    .push_dat_i (tx_data),
    .pop_i      (pop_d),
    .pop_dat_o  (fifo_head),
    .count_o    (fifo_cnt),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // tx and busy are registered alongside the state so each reflects the
  // state entered on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          tx_q   <= 1'b1;
          if (pop_d) begin
            shift_q  <= fifo_head;
            parity_q <= ^fifo_head;
            state_q  <= S_START;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
          end
        end

        S_START: begin
          if (baud_done) begin
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            state_q   <= S_DATA;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              if (PARITY_EN) begin
                state_q <= S_PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              // Next bit is the one about to move into position 0.
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

        S_PARITY: begin
          if (baud_done) begin
            baud_q  <= '0;
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            if (pop_d) begin
              shift_q  <= fifo_head;
              parity_q <= ^fifo_head;
              state_q  <= S_START;
              tx_q     <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          baud_q  <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ws.sv
// tb_uart_tx_ws: directed and randomized checks of uart_tx_ws, 8N1 and 8E1 instances.
// Latency: expected waveforms are cycle-exact from the push edge.
// Backpressure: FIFO-full drop and ena gating are exercised directly.
module tb_uart_tx_ws;

  localparam int C = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] tx_data;
  logic       tx_valid0, tx_valid1;
  logic       tx_ready0, tx_ready1;
  logic       tx0, tx1;
  logic       busy0, busy1;
  logic [2:0] fifo_count0, fifo_count1;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_ws #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid0),
    .tx_ready   (tx_ready0),
    .tx         (tx0),
    .busy       (busy0),
    .fifo_count (fifo_count0)
  );

  uart_tx_ws #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid1),
    .tx_ready   (tx_ready1),
    .tx         (tx1),
    .busy       (busy1),
    .fifo_count (fifo_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  function automatic logic get_tx(input int sel);
    return (sel == 1) ? tx1 : tx0;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 1) ? busy1 : busy0;
  endfunction

  function automatic logic get_rdy(input int sel);
    return (sel == 1) ? tx_ready1 : tx_ready0;
  endfunction

  function automatic logic [2:0] get_cnt(input int sel);
    return (sel == 1) ? fifo_count1 : fifo_count0;
  endfunction

  // Reference frame: bit k of the line for byte b. 0 = start, 1..8 = data
  // LSB first, then even parity (if enabled), then stop.
  function automatic logic exp_bit(input logic [7:0] b, input bit par_en, input int k);
    int ones;
    int v;
    int p;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      v = (int'(b) >> i) % 2;
      ones += v;
    end
    if (k == 0) return 1'b0;
    if (k <= 8) begin
      v = (int'(b) >> (k - 1)) % 2;
      return v[0];
    end
    if (par_en && k == 9) begin
      p = ones % 2;
      return p[0];
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] d);
    tx_data = d;
    if (sel == 1) tx_valid1 = 1'b1;
    else          tx_valid0 = 1'b1;
    @(negedge clk);
    tx_valid0 = 1'b0;
    tx_valid1 = 1'b0;
  endtask

  // Called on the negedge of the first start-bit cycle; returns on the
  // negedge following the last stop cycle. drop_at >= 0 clears ena after
  // that many frame cycles.
  task automatic check_frame(input int sel, input logic [7:0] b, input int drop_at);
    int nb;
    nb = (sel == 1) ? 11 : 10;
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < C; c++) begin
        chk($sformatf("frame%0d_%02h_bit%0d_tx", sel, b, k), 32'(get_tx(sel)),
            32'(exp_bit(b, sel == 1, k)));
        chk($sformatf("frame%0d_%02h_bit%0d_busy", sel, b, k), 32'(get_busy(sel)), 32'd1);
        if (k * C + c == drop_at) ena = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic check_idle(input int sel, input int cycles, input int cnt);
    for (int i = 0; i < cycles; i++) begin
      chk($sformatf("idle%0d_tx", sel), 32'(get_tx(sel)), 32'd1);
      chk($sformatf("idle%0d_busy", sel), 32'(get_busy(sel)), 32'd0);
      chk($sformatf("idle%0d_count", sel), 32'(get_cnt(sel)), 32'(cnt));
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] b;
    int sel;
    int k;

    rst_n     = 1'b0;
    ena       = 1'b0;
    tx_data   = 8'h00;
    tx_valid0 = 1'b0;
    tx_valid1 = 1'b0;

    // Reset values with the clock running.
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst%0d_tx", s), 32'(get_tx(s)), 32'd1);
      chk($sformatf("rst%0d_busy", s), 32'(get_busy(s)), 32'd0);
      chk($sformatf("rst%0d_ready", s), 32'(get_rdy(s)), 32'd1);
      chk($sformatf("rst%0d_count", s), 32'(get_cnt(s)), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte 0xA5, 8N1: count 1 after the push edge, start one edge later.
    ena = 1'b1;
    push(0, 8'hA5);
    chk("a5_count_after_push", 32'(fifo_count0), 32'd1);
    chk("a5_tx_before_start", 32'(tx0), 32'd1);
    chk("a5_busy_before_start", 32'(busy0), 32'd0);
    @(negedge clk);
    chk("a5_count_after_pop", 32'(fifo_count0), 32'd0);
    check_frame(0, 8'hA5, -1);
    check_idle(0, 8, 0);

    // Parity frames: 0x07 -> parity 1, 0x03 -> parity 0.
    push(1, 8'h07);
    @(negedge clk);
    check_frame(1, 8'h07, -1);
    check_idle(1, 4, 0);
    push(1, 8'h03);
    @(negedge clk);
    check_frame(1, 8'h03, -1);
    check_idle(1, 4, 0);

    // Fill the FIFO with ena low, drop a fifth byte, then drain back-to-back.
    ena = 1'b0;
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    push(0, 8'h44);
    chk("full_count", 32'(fifo_count0), 32'd4);
    chk("full_ready", 32'(tx_ready0), 32'd0);
    push(0, 8'h55);
    chk("full_drop_count", 32'(fifo_count0), 32'd4);
    chk("full_ena0_tx", 32'(tx0), 32'd1);
    ena = 1'b1;
    @(negedge clk);
    chk("drain_first_count", 32'(fifo_count0), 32'd3);
    chk("drain_ready_back", 32'(tx_ready0), 32'd1);
    check_frame(0, 8'h11, -1);
    check_frame(0, 8'h22, -1);
    check_frame(0, 8'h33, -1);
    check_frame(0, 8'h44, -1);
    check_idle(0, 12, 0);

    // ena dropped during the DATA state of 0x3C; 0xC3 waits in the FIFO.
    push(0, 8'h3C);
    push(0, 8'hC3);
    chk("enadrop_count", 32'(fifo_count0), 32'd1);
    check_frame(0, 8'h3C, 3 * C + 1);
    check_idle(0, 3 * C, 1);
    ena = 1'b1;
    @(negedge clk);
    check_frame(0, 8'hC3, -1);
    check_idle(0, 4, 0);

    // Push on the same edge as a pop with two bytes queued.
    ena = 1'b0;
    push(0, 8'hAA);
    push(0, 8'hBB);
    chk("pushpop_pre_count", 32'(fifo_count0), 32'd2);
    ena = 1'b1;
    push(0, 8'hCC);
    chk("pushpop_count", 32'(fifo_count0), 32'd2);
    check_frame(0, 8'hAA, -1);
    check_frame(0, 8'hBB, -1);
    check_frame(0, 8'hCC, -1);
    check_idle(0, 4, 0);

    // Reset mid-frame: tx must return high without a clock edge and the
    // queued byte must be discarded.
    push(0, 8'h00);
    push(0, 8'h5A);
    repeat (3 * C) @(negedge clk);
    chk("midrst_pre_tx", 32'(tx0), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx0), 32'd1);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_count", 32'(fifo_count0), 32'd0);
    chk("midrst_ready", 32'(tx_ready0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(0, 12, 0);

    // Randomized bursts of 1..4 bytes into either instance.
    for (int r = 0; r < 10; r++) begin
      sel = $urandom_range(0, 1);
      k   = $urandom_range(1, 4);
      q.delete();
      ena = 1'b0;
      for (int i = 0; i < k; i++) begin
        b = 8'($urandom);
        push(sel, b);
        q.push_back(b);
      end
      chk($sformatf("rand%0d_count", r), 32'(get_cnt(sel)), 32'(k));
      ena = 1'b1;
      @(negedge clk);
      for (int i = 0; i < k; i++) check_frame(sel, q[i], -1);
      check_idle(sel, 4, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_ws.md
# uart_tx_ws

Buffered UART transmitter for the Tiny Tapeout user project. It drives a serial line out on a dedicated output pin (uo_out[0] at top level), so the design can stream bytes back to the host instead of only receiving stimulus on ui_in/uio_in. Bytes enter through a valid/ready handshake into a 4-entry FIFO and are serialized as 8N1 frames, or 8E1 when parity is enabled.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clock cycles per serial bit. Legal range is 2..65535, and it sets the width of the baud counter.
- PARITY_EN, default 0: 1 inserts an even-parity bit between D7 and the stop bit.

Ports:
- clk, input, 1: the only clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- ena, input, 1: transmit enable. It gates the start of new frames only.
- tx_data, input, 8: byte to send.
- tx_valid, input, 1: tx_data is valid this cycle.
- tx_ready, output, 1: FIFO can accept a byte. Equal to !full.
- tx, output, 1: serial line, idle high. Registered.
- busy, output, 1: high while a frame is in progress (FSM not IDLE).
- fifo_count, output, 3: FIFO occupancy, 0..4.

## Operation
- Reset (asynchronous assert, synchronous effect on release) gives: tx=1, busy=0, tx_ready=1, fifo_count=0, FSM=IDLE, baud counter=0, FIFO pointers=0.
- Push: a byte is pushed when tx_valid && tx_ready at a rising edge. Data offered while tx_ready=0 is ignored; tx_data need not be held.
- FIFO:
  - 4 entries, first in first out.
  - Pointers are 2 bits and wrap from 3 to 0.
  - Full means fifo_count==4; empty means fifo_count==0.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - No push is possible when full, so a pop frees a slot only from the next cycle.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If ena && !empty, pop the head byte into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit index 7, go to PARITY if PARITY_EN, otherwise go to STOP.
  - PARITY: tx = XOR of the 8 data bits, held for CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last stop cycle, if ena && !empty, pop and go straight to START with no idle gap. Otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - Advances the bit or state at terminal count, then reloads to 0.
  - Held at 0 in IDLE.
- ena deasserted mid-frame: the current frame completes unchanged, and no new frame starts. FIFO pushes are still accepted while ena=0.
- Reset asserted mid-frame: the frame is aborted and tx returns to 1 immediately (asynchronous). FIFO contents are discarded.

## Timing
- Latency: for a push at edge E with FSM IDLE, ena=1 and the FIFO empty:
  - pop and START entry happen at E+1, so tx=0 is visible after E+1;
  - fifo_count reads 1 after E and 0 after E+1.
- Frame length is 10·CLKS_PER_BIT cycles (11·CLKS_PER_BIT with PARITY_EN=1).
- Back-to-back frames: the next start bit begins on the cycle right after the last stop cycle.
- busy rises at the same edge tx first goes 0, and falls at the same edge the FSM enters IDLE.
- tx_ready is combinational from fifo_count. It returns to 1 in the cycle after a pop from a full FIFO.

## Test plan
- Reset values: with rst_n=0 and clk running, check tx=1, busy=0, tx_ready=1, fifo_count=0. Assert rst_n=0 mid-frame: tx must return to 1 without waiting for a clock edge.
- Single byte, CLKS_PER_BIT=4, PARITY_EN=0: push 0xA5. tx must be 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles (40 cycles total), with start at the second edge after the push. busy is high for exactly 40 cycles.
- Parity, CLKS_PER_BIT=4, PARITY_EN=1: push 0x07. The data bits are followed by parity bit 1, then the stop bit; frame is 44 cycles. Push 0x03: parity bit is 0.
- FIFO full and back-to-back: with ena=0, push 0x11, 0x22, 0x33, 0x44.
  - fifo_count must reach 4 and tx_ready go 0; a fifth push of 0x55 is dropped.
  - Raise ena: four contiguous frames 0x11, 0x22, 0x33, 0x44 follow with no idle cycles between stop and start, then the FSM goes to IDLE.
- ena drop mid-frame: push 0x3C and 0xC3, then deassert ena during 0x3C's DATA state. 0x3C completes, tx stays 1, and fifo_count=1 persists. Reasserting ena sends 0xC3.
- Push and pop in the same cycle: with fifo_count=2, push on the exact edge the FSM pops. fifo_count stays 2 and byte order is preserved.
